product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the 4x4 sequential multiplier's 8-bit product.
- Sums a run of products into a wider accumulator, for dot-product and MAC-style use.
- Emits one sum per run over a valid/ready handshake.
- A run ends after TERMS products or on an early in_last.

Parameters:
- PROD_W, 8, width of incoming product.
- ACC_W, 16, accumulator and out_sum width; must be >= PROD_W+1.
- TERMS, 4, maximum products per run; must be >= 1.
- CNT_W, 3, width of out_count; must hold the value TERMS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_product is valid this cycle.
- in_ready  output  1  block accepts a product this cycle.
- in_product  input  PROD_W  unsigned product from the multiplier.
- in_last  input  1  qualified by in_valid; this product ends the run early.
- out_valid  output  1  out_sum, out_count and out_overflow are valid.
- out_ready  input  1  downstream takes the result this cycle.
- out_sum  output  ACC_W  accumulated unsigned sum, saturated.
- out_count  output  CNT_W  number of products in the run.
- out_overflow  output  1  sum saturated at some point during the run.

Behaviour:
- Single clock. Reset is synchronous and active-high, and all state updates happen on the rising edge of clk.
- Reset values:
  - state=ACCUM, accumulator=0, count=0, overflow flag=0.
  - out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - in_ready=1 on the first cycle after reset is released.
- Reset asserted mid-run or mid-output discards all partial or pending results with no output.
- Accept: a product is accepted on any cycle where in_valid and in_ready are both 1.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc_next = acc + zero-extended in_product, and count increments.
  - If acc_next exceeds 2^ACC_W-1, acc becomes all-ones and the overflow flag is set. The flag is sticky for the rest of the run; acc stays saturated.
  - If the accepted product is the TERMS-th of the run, or in_last=1, go to state DONE.
  - On that same edge, load out_sum (the final acc including this product), out_count (the final count) and out_overflow.
  - Latency: out_valid rises on the first cycle after the final accept.
- State DONE:
  - in_ready=0 and out_valid=1.
  - out_sum, out_count and out_overflow are held stable while out_ready=0.
  - When out_ready=1: clear acc, count and the overflow flag, and return to ACCUM.
  - out_valid=0 and in_ready=1 on the next cycle.
  - No same-cycle bypass: the earliest next-run accept is one cycle after the output handshake.
- Inputs ignored:
  - in_product and in_last are ignored when in_valid=0.
  - in_valid is ignored while in_ready=0. The upstream must hold the product until it is accepted.
- in_last on the TERMS-th product behaves exactly like a normal terminal product, with no double-count.
- TERMS=1: every accepted product forms its own run; out_count=1.
- Zero-valued products count as terms.
- out_* outputs keep their last values after the handshake until the next run's load; only out_valid qualifies them.
- No stall inside ACCUM: the block accepts one product per cycle indefinitely.

Test Plan:
1. Defaults; in_valid=1 for 4 cycles with products 10, 20, 30, 40 and out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_sum=100, out_count=4, out_overflow=0. in_ready returns to 1 two cycles after the 4th accept.
2. Early end: products 200 then 55 with in_last=1 on the 2nd -> out_sum=255, out_count=2. The next run starts from acc=0: a single product 7 with in_last gives out_sum=7, out_count=1.
3. Saturation with ACC_W=9: products 255, 255, 255, 1 -> out_sum=511, out_count=4, out_overflow=1. The next run of 1, 1, 1, 1 -> out_sum=4, out_overflow=0.
4. Backpressure: complete a run of 5, 5, 5, 5 with out_ready=0 for 6 cycles -> out_valid stays 1 with out_sum=20 unchanged. in_ready=0 throughout, and in_valid=1 pulses with product 99 are not accepted. Raise out_ready -> handshake occurs, and 99 is accepted on the following cycle.
5. Reset mid-run: accept 50 and 60, assert reset for 1 cycle -> all outputs are 0 and in_ready=1 after reset. A subsequent run of 1, 2, 3, 4 -> out_sum=10, out_count=4.
6. Bubbles: products 3, 4, 5, 6 with in_valid gaps of 0-3 cycles between them -> out_sum=18, out_count=4. out_valid rises exactly one cycle after the 4th accept.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums a run of unsigned products into a saturating
// accumulator and hands the result downstream over valid/ready.
// A run closes after TERMS products or on an in_last-tagged product.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int TERMS  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    // Sum is one bit wider so the carry out flags saturation.
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             terminal;

    assign in_ready     = (state_q == ST_ACCUM);
    assign out_valid    = (state_q == ST_DONE);
    assign out_sum      = out_sum_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

    // Next-state, accumulate/saturate and result-load logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        accept   = in_valid && in_ready;
        sum_wide = {1'b0, acc_q} + (ACC_W+1)'(in_product);
        ovf_next = ovf_q || sum_wide[ACC_W];
        // Once saturated the accumulator stays pinned at all-ones.
        acc_next = ovf_next ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        cnt_inc  = cnt_q + CNT_W'(1);
        terminal = in_last || (cnt_inc == CNT_W'(TERMS));

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = acc_next;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_next;
                    if (terminal) begin
                        state_d     = ST_DONE;
                        out_sum_d   = acc_next;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_next;
                    end
                end
            end
            default: begin
                // Result stays held until the consumer takes it; no bypass
                // into a new run on the handshake cycle.
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. Two instances share stimulus:
// u_dut uses default widths, u_sat uses ACC_W=9 to reach saturation.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_product;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_overflow;
    logic [15:0] out_sum;
    logic [2:0]  out_count;

    logic        s_in_ready, s_out_valid, s_out_overflow;
    logic [8:0]  s_out_sum;
    logic [2:0]  s_out_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    product_accumulator u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_overflow(out_overflow)
    );

    product_accumulator #(.ACC_W(9)) u_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_product(in_product), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum(s_out_sum), .out_count(s_out_count), .out_overflow(s_out_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a product and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] p, input logic last);
        int budget;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        budget     = 20;
        while (!in_ready && budget > 0) begin
            step();
            budget--;
        end
        chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("bubble_no_valid", {31'd0, out_valid}, 32'd0);
            step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_product = 8'd0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready",  {31'd0, in_ready},     32'd1);
        chk("rst_out_valid", {31'd0, out_valid},    32'd0);
        chk("rst_sum",       {16'd0, out_sum},      32'd0);
        chk("rst_count",     {29'd0, out_count},    32'd0);
        chk("rst_ovf",       {31'd0, out_overflow}, 32'd0);

        // 1: full run of four
        send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
        chk("t1_valid",    {31'd0, out_valid},    32'd1);
        chk("t1_sum",      {16'd0, out_sum},      32'd100);
        chk("t1_count",    {29'd0, out_count},    32'd4);
        chk("t1_ovf",      {31'd0, out_overflow}, 32'd0);
        chk("t1_ready_lo", {31'd0, in_ready},     32'd0);
        step();
        chk("t1_valid_lo", {31'd0, out_valid},    32'd0);
        chk("t1_ready_hi", {31'd0, in_ready},     32'd1);
        chk("t1_sum_held", {16'd0, out_sum},      32'd100);

        // 2: early end, then a one-term run from a fresh accumulator
        send(8'd200, 1'b0); send(8'd55, 1'b1);
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_sum",   {16'd0, out_sum},   32'd255);
        chk("t2_count", {29'd0, out_count}, 32'd2);
        send(8'd7, 1'b1);
        chk("t2b_sum",   {16'd0, out_sum},   32'd7);
        chk("t2b_count", {29'd0, out_count}, 32'd1);
        step();

        // 3: saturation on the 9-bit instance
        send(8'd255, 1'b0); send(8'd255, 1'b0); send(8'd255, 1'b0); send(8'd1, 1'b0);
        chk("t3_sat_valid", {31'd0, s_out_valid},    32'd1);
        chk("t3_sat_sum",   {23'd0, s_out_sum},      32'd511);
        chk("t3_sat_count", {29'd0, s_out_count},    32'd4);
        chk("t3_sat_ovf",   {31'd0, s_out_overflow}, 32'd1);
        chk("t3_wide_sum",  {16'd0, out_sum},        32'd766);
        chk("t3_wide_ovf",  {31'd0, out_overflow},   32'd0);
        step();
        send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
        chk("t3b_sat_sum", {23'd0, s_out_sum},      32'd4);
        chk("t3b_sat_ovf", {31'd0, s_out_overflow}, 32'd0);
        step();

        // 4: backpressure
        out_ready = 1'b0;
        send(8'd5, 1'b0); send(8'd5, 1'b0); send(8'd5, 1'b0); send(8'd5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            in_valid   = (i % 2 == 0);
            in_product = 8'd99;
            in_last    = 1'b1;
            chk("t4_valid_held", {31'd0, out_valid}, 32'd1);
            chk("t4_sum_held",   {16'd0, out_sum},   32'd20);
            chk("t4_ready_lo",   {31'd0, in_ready},  32'd0);
            step();
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("t4_hs_valid_lo", {31'd0, out_valid}, 32'd0);
        chk("t4_hs_ready_hi", {31'd0, in_ready},  32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("t4_99_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_99_sum",   {16'd0, out_sum},   32'd99);
        chk("t4_99_count", {29'd0, out_count}, 32'd1);
        step();

        // 5: reset mid-run
        send(8'd50, 1'b0); send(8'd60, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_valid", {31'd0, out_valid},    32'd0);
        chk("t5_ready", {31'd0, in_ready},     32'd1);
        chk("t5_sum",   {16'd0, out_sum},      32'd0);
        chk("t5_count", {29'd0, out_count},    32'd0);
        chk("t5_ovf",   {31'd0, out_overflow}, 32'd0);
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
        chk("t5b_sum",   {16'd0, out_sum},   32'd10);
        chk("t5b_count", {29'd0, out_count}, 32'd4);
        step();

        // 6: bubbles between products
        send(8'd3, 1'b0); idle(2);
        send(8'd4, 1'b0);
        send(8'd5, 1'b0); idle(3);
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd0);
        send(8'd6, 1'b0);
        chk("t6_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_sum",   {16'd0, out_sum},   32'd18);
        chk("t6_count", {29'd0, out_count}, 32'd4);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
